// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS core: PC register, I-cache fetch sequencer and IF/ID register.
// Cache misses hold the PC; a redirect taken during a miss is parked until the stale word returns.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic        IF_Flush,
    input  logic        Jump,
    input  logic        JumpR,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    output logic [31:0] pc_out,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid
);
    typedef enum logic [1:0] {ST_RUN, ST_MISS, ST_KILL} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_inst, w_inst_next;
    logic [31:0] r_pc4, w_pc4_next;
    logic        r_valid, w_valid_next;
    logic        r_ren;
    logic [31:0] r_pend_tgt, w_pend_tgt_next;
    logic        r_pend_vld, w_pend_vld_next;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Redirects seen under a load-use stall are dropped; ID presents them again afterwards.
    assign w_redirect   = (JumpR | Jump | PCSrc) & ~stall;
    assign w_target_raw = JumpR ? jr_target :
                          Jump  ? {r_pc4[31:28], r_inst[25:0], 2'b00} :
                                  branch_target;
    assign w_target     = w_target_raw & 32'hFFFF_FFFC;
    assign w_pc_plus4   = r_pc + 32'd4;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_inst_next     = r_inst;
        w_pc4_next      = r_pc4;
        w_valid_next    = r_valid;
        w_pend_tgt_next = r_pend_tgt;
        w_pend_vld_next = r_pend_vld;
        if (r_ren) begin
            if (ICACHE_stall) begin
                if (!stall) begin
                    w_inst_next  = NOP_INST;
                    w_pc4_next   = 32'd0;
                    w_valid_next = 1'b0;
                end
                if (w_redirect) begin
                    w_pend_tgt_next = w_target;
                    w_pend_vld_next = 1'b1;
                    w_state_next    = ST_KILL;
                end else if (r_state == ST_RUN) begin
                    w_state_next = ST_MISS;
                end
            end else if (r_state == ST_KILL) begin
                // The word returned here belongs to the abandoned path.
                w_pc_next       = w_redirect ? w_target : (r_pend_vld ? r_pend_tgt : r_pc);
                w_pend_vld_next = 1'b0;
                w_state_next    = ST_RUN;
                if (!stall) begin
                    w_inst_next  = NOP_INST;
                    w_pc4_next   = 32'd0;
                    w_valid_next = 1'b0;
                end
            end else begin
                w_state_next = ST_RUN;
                if (!stall) begin
                    if (w_redirect || IF_Flush) begin
                        w_pc_next    = w_redirect ? w_target : w_pc_plus4;
                        w_inst_next  = NOP_INST;
                        w_pc4_next   = 32'd0;
                        w_valid_next = 1'b0;
                    end else begin
                        w_pc_next    = w_pc_plus4;
                        w_inst_next  = ICACHE_rdata;
                        w_pc4_next   = w_pc_plus4;
                        w_valid_next = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_inst     <= NOP_INST;
            r_pc4      <= 32'd0;
            r_valid    <= 1'b0;
            r_ren      <= 1'b0;
            r_pend_tgt <= 32'd0;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_inst     <= w_inst_next;
            r_pc4      <= w_pc4_next;
            r_valid    <= w_valid_next;
            r_ren      <= 1'b1;
            r_pend_tgt <= w_pend_tgt_next;
            r_pend_vld <= w_pend_vld_next;
        end
    end

    assign ICACHE_ren     = r_ren;
    assign ICACHE_addr    = r_pc[31:2];
    assign pc_out         = r_pc;
    assign IF_ID_inst     = r_inst;
    assign IF_ID_pc_plus4 = r_pc4;
    assign IF_ID_valid    = r_valid;
endmodule
